// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//
// MEM/WB pipeline stage. It selects one of NUM_SRC result sources, optionally
// aligns and extends load data, and registers the result towards the GPR write
// port. It also provides a forwarding tap and a retired-instruction counter.
//
// Optional feature macro: WB_LOAD_ALIGN_EN
//   defined   : the memory source (MEM_SRC) is aligned and extended from the low
//               32 bits, and misaligned half/word loads are flagged.
//   undefined : the memory source passes through unmodified, load_size,
//               load_signed and byte_off are ignored, and misalign_err is 0.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   stall          hold every stage register (misalign_err is cleared)
//   flush          kill the incoming instruction (stage valid and gpr_we cleared)
//   in_valid       incoming instruction valid
//   src_data       packed sources, source i at [i*DATA_W +: DATA_W]
//   src_sel        source select; out-of-range selects give 0
//   reg_write      instruction writes a GPR
//   rd_addr        destination register; r0 writes are suppressed
//   load_size      00 byte, 01 half, 10/11 word
//   load_signed    sign-extend sub-word loads
//   byte_off       load address bits [1:0]
//   gpr_we/waddr/wdata   registered GPR write port
//   fwd_valid/addr/data  forwarding tap, identical to the GPR write port
//   misalign_err   one-cycle pulse for a misaligned load
//   retired        retired-instruction count, wraps at 2^32
//
// Stage protocol: there is no back-pressure output. While stall is high the
// stage holds its contents and the upstream stage must hold its instruction;
// a held gpr_we repeats the same write, which the register file absorbs.
// -----------------------------------------------------------------------------
module writeback_unit #(
    parameter  int DATA_W  = 32,
    parameter  int NUM_SRC = 4,
    parameter  int MEM_SRC = 1,
    parameter  int REG_AW  = 5,
    localparam int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]          src_sel,
    input  logic                      reg_write,
    input  logic [REG_AW-1:0]         rd_addr,
    input  logic [1:0]                load_size,
    input  logic                      load_signed,
    input  logic [1:0]                byte_off,
    output logic                      gpr_we,
    output logic [REG_AW-1:0]         gpr_waddr,
    output logic [DATA_W-1:0]         gpr_wdata,
    output logic                      fwd_valid,
    output logic [REG_AW-1:0]         fwd_addr,
    output logic [DATA_W-1:0]         fwd_data,
    output logic                      misalign_err,
    output logic [31:0]               retired
);

    logic [DATA_W-1:0] mux_raw;
    logic [DATA_W-1:0] result;
    logic              misaligned;

    logic              valid_q;
    logic              we_q;
    logic [REG_AW-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [31:0]       retired_q;

    // Source mux; a select with no matching source leaves the result at 0.
    always_comb begin
        mux_raw = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_sel == SEL_W'(i)) begin
                mux_raw = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef WB_LOAD_ALIGN_EN
    logic        mem_sel;
    logic [31:0] mem_lo;
    logic [31:0] byte_shift;
    logic [7:0]  byte_field;
    logic [15:0] half_field;
    logic [DATA_W-1:0] aligned;

    assign mem_sel = (src_sel == SEL_W'(MEM_SRC));

    // Alignment works on the low 32 bits only; the sized casts below extend
    // the extracted field to DATA_W with its sign when the cast operand is
    // signed and with zeros otherwise.
    always_comb begin
        mem_lo     = mux_raw[31:0];
        byte_shift = mem_lo >> {byte_off, 3'b000};
        byte_field = byte_shift[7:0];
        half_field = byte_off[1] ? mem_lo[31:16] : mem_lo[15:0];
        aligned    = '0;
        case (load_size)
            2'b00: aligned = load_signed ? DATA_W'($signed(byte_field)) : DATA_W'(byte_field);
            2'b01: aligned = load_signed ? DATA_W'($signed(half_field)) : DATA_W'(half_field);
            default: aligned = load_signed ? DATA_W'($signed(mem_lo)) : DATA_W'(mem_lo);
        endcase
    end

    assign result = mem_sel ? aligned : mux_raw;

    // load_size[1] covers both word encodings (10 and reserved 11).
    assign misaligned = mem_sel &&
                        (((load_size == 2'b01) && byte_off[0]) ||
                         (load_size[1] && (byte_off != 2'b00)));
`else
    assign result     = mux_raw;
    assign misaligned = 1'b0;

    logic unused_align;
    assign unused_align = ^{load_size, load_signed, byte_off};
`endif

    // Stage register: reset, then flush, then stall, then capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (flush) begin
            // Address and data are left stale; gpr_we = 0 makes them inert.
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (stall) begin
            // Everything holds except the error pulse, which must not repeat.
            err_q   <= 1'b0;
        end else begin
            valid_q <= in_valid;
            we_q    <= in_valid & reg_write & (rd_addr != '0) & ~misaligned;
            waddr_q <= rd_addr;
            wdata_q <= result;
            err_q   <= in_valid & misaligned;
        end
    end

    // The instruction sitting in the stage retires on any non-stalled cycle,
    // including one in which the next instruction is flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else if (valid_q && !stall) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign gpr_we       = we_q;
    assign gpr_waddr    = waddr_q;
    assign gpr_wdata    = wdata_q;
    assign fwd_valid    = we_q;
    assign fwd_addr     = waddr_q;
    assign fwd_data     = wdata_q;
    assign misalign_err = err_q;
    assign retired      = retired_q;

endmodule

// File: tb/tb_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_writeback_unit
//
// Bench for writeback_unit with default parameters. A table of single-cycle
// vectors covers the source mux, load alignment, r0 suppression and
// misalignment; hand-written sequences cover stall, flush, counter wrap and
// reset during stall. Expected load results depend on WB_LOAD_ALIGN_EN.
// -----------------------------------------------------------------------------
module tb_writeback_unit;

`ifdef WB_LOAD_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         stall;
    logic         flush;
    logic         in_valid;
    logic [127:0] src_data;
    logic [1:0]   src_sel;
    logic         reg_write;
    logic [4:0]   rd_addr;
    logic [1:0]   load_size;
    logic         load_signed;
    logic [1:0]   byte_off;
    logic         gpr_we;
    logic [4:0]   gpr_waddr;
    logic [31:0]  gpr_wdata;
    logic         fwd_valid;
    logic [4:0]   fwd_addr;
    logic [31:0]  fwd_data;
    logic         misalign_err;
    logic [31:0]  retired;

    always #5 clk = ~clk;

    writeback_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .src_data     (src_data),
        .src_sel      (src_sel),
        .reg_write    (reg_write),
        .rd_addr      (rd_addr),
        .load_size    (load_size),
        .load_signed  (load_signed),
        .byte_off     (byte_off),
        .gpr_we       (gpr_we),
        .gpr_waddr    (gpr_waddr),
        .gpr_wdata    (gpr_wdata),
        .fwd_valid    (fwd_valid),
        .fwd_addr     (fwd_addr),
        .fwd_data     (fwd_data),
        .misalign_err (misalign_err),
        .retired      (retired)
    );

    // ---------------- vectors ----------------
    typedef struct {
        logic        v;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [1:0]  size;
        logic        sg;
        logic [1:0]  off;
        logic        we;    // expected gpr_we when captured
        logic [31:0] data;  // expected gpr_wdata when captured
        logic        err;   // expected misalign_err when captured
    } vec_t;

    vec_t vecs[$];

    logic [31:0] s0, s1, s2, s3;

    // ---------------- scoreboard ----------------
    // {check addr/data, we, addr, data, err, retired}
    logic [71:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    // bench model of the stage
    logic        m_valid;
    logic [31:0] m_ret;
    logic        l_chk, l_we;
    logic [4:0]  l_addr;
    logic [31:0] l_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, push the expected
    // registered outputs, then compare them just after the rising edge.
    task automatic run_cycle(input string name, input logic r, input logic s,
                             input logic f, input vec_t vv);
        logic [71:0] e;
        logic        n_chk, n_we, n_err, n_valid;
        logic [4:0]  n_addr;
        logic [31:0] n_data, n_ret;
        @(negedge clk);
        rst         = r;
        stall       = s;
        flush       = f;
        in_valid    = vv.v;
        reg_write   = vv.rw;
        rd_addr     = vv.rd;
        src_sel     = vv.sel;
        load_size   = vv.size;
        load_signed = vv.sg;
        byte_off    = vv.off;
        src_data    = {s3, s2, s1, s0};

        if (r) begin
            n_chk = 1'b1; n_we = 1'b0; n_addr = '0; n_data = '0;
            n_err = 1'b0; n_valid = 1'b0; n_ret = '0;
        end else if (f) begin
            n_chk = 1'b0; n_we = 1'b0; n_addr = l_addr; n_data = l_data;
            n_err = 1'b0; n_valid = 1'b0;
            n_ret = m_ret + ((m_valid && !s) ? 32'd1 : 32'd0);
        end else if (s) begin
            n_chk = l_chk; n_we = l_we; n_addr = l_addr; n_data = l_data;
            n_err = 1'b0; n_valid = m_valid; n_ret = m_ret;
        end else begin
            n_chk = vv.we; n_we = vv.we; n_addr = vv.rd; n_data = vv.data;
            n_err = vv.err; n_valid = vv.v;
            n_ret = m_ret + (m_valid ? 32'd1 : 32'd0);
        end
        exp_q.push_back({n_chk, n_we, n_addr, n_data, n_err, n_ret});

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({name, ".gpr_we"},    32'(gpr_we),       32'(e[70]));
        chk({name, ".fwd_valid"}, 32'(fwd_valid),    32'(e[70]));
        chk({name, ".misalign"},  32'(misalign_err), 32'(e[32]));
        chk({name, ".retired"},   retired,           e[31:0]);
        if (e[71]) begin
            chk({name, ".gpr_waddr"}, 32'(gpr_waddr), 32'(e[69:65]));
            chk({name, ".fwd_addr"},  32'(fwd_addr),  32'(e[69:65]));
            chk({name, ".gpr_wdata"}, gpr_wdata,      e[64:33]);
            chk({name, ".fwd_data"},  fwd_data,       e[64:33]);
        end

        m_valid = n_valid;
        m_ret   = n_ret;
        l_chk   = n_chk;
        l_we    = n_we;
        l_addr  = n_addr;
        l_data  = n_data;
    endtask

    // ---------------- test ----------------
    vec_t idle, mis, w;

    initial begin
        s0 = 32'h1234_5678; s1 = 32'hAABB_CCDD; s2 = 32'h0F0F_0001; s3 = 32'h0000_1000;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; reg_write = 1'b0;
        rd_addr = '0; src_sel = '0; load_size = '0; load_signed = 1'b0; byte_off = '0;
        src_data = '0;
        m_valid = 1'b0; m_ret = '0; l_chk = 1'b0; l_we = 1'b0; l_addr = '0; l_data = '0;

        idle = '{1'b0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0};

        //            v  rw rd  sel size sg off  we        data                                   err
        vecs.push_back('{1, 1, 5,  0, 0, 0, 0, 1, 32'h1234_5678, 0});
        vecs.push_back('{1, 1, 3,  1, 0, 1, 2, 1, ALIGN ? 32'hFFFF_FFBB : 32'hAABB_CCDD, 0});
        vecs.push_back('{1, 1, 3,  1, 0, 0, 2, 1, ALIGN ? 32'h0000_00BB : 32'hAABB_CCDD, 0});
        vecs.push_back('{1, 1, 4,  1, 1, 0, 1, !ALIGN, 32'hAABB_CCDD, ALIGN});
        vecs.push_back('{1, 1, 4,  1, 1, 1, 2, 1, ALIGN ? 32'hFFFF_AABB : 32'hAABB_CCDD, 0});
        vecs.push_back('{1, 1, 6,  1, 2, 0, 0, 1, 32'hAABB_CCDD, 0});
        vecs.push_back('{1, 1, 6,  1, 2, 1, 2, !ALIGN, 32'hAABB_CCDD, ALIGN});
        vecs.push_back('{1, 1, 8,  1, 3, 1, 0, 1, 32'hAABB_CCDD, 0});
        vecs.push_back('{1, 1, 0,  0, 0, 0, 0, 0, 32'h1234_5678, 0});
        vecs.push_back('{1, 0, 9,  0, 0, 0, 0, 0, 32'h1234_5678, 0});
        vecs.push_back('{0, 1, 9,  0, 0, 0, 0, 0, 32'h1234_5678, 0});
        vecs.push_back('{1, 1, 31, 2, 0, 0, 0, 1, 32'h0F0F_0001, 0});
        vecs.push_back('{1, 1, 1,  3, 0, 0, 0, 1, 32'h0000_1000, 0});
        vecs.push_back('{1, 1, 10, 0, 1, 0, 1, 1, 32'h1234_5678, 0});
        vecs.push_back('{1, 1, 11, 1, 0, 0, 3, 1, ALIGN ? 32'h0000_00AA : 32'hAABB_CCDD, 0});
        vecs.push_back('{1, 1, 12, 1, 0, 1, 1, 1, ALIGN ? 32'hFFFF_FFCC : 32'hAABB_CCDD, 0});
        vecs.push_back('{1, 1, 13, 1, 0, 1, 0, 1, ALIGN ? 32'hFFFF_FFDD : 32'hAABB_CCDD, 0});
        vecs.push_back('{1, 1, 14, 1, 1, 1, 0, 1, ALIGN ? 32'hFFFF_CCDD : 32'hAABB_CCDD, 0});
        vecs.push_back('{1, 1, 15, 1, 1, 0, 2, 1, ALIGN ? 32'h0000_AABB : 32'hAABB_CCDD, 0});

        // reset state
        run_cycle("reset0", 1'b1, 1'b0, 1'b0, idle);
        run_cycle("reset1", 1'b1, 1'b0, 1'b0, idle);

        // table
        for (int i = 0; i < vecs.size(); i++) begin
            run_cycle($sformatf("vec%0d", i), 1'b0, 1'b0, 1'b0, vecs[i]);
        end

        // random ALU writes
        for (int i = 0; i < 20; i++) begin
            s0 = $urandom;
            w = '{1'b1, 1'b1, 5'($urandom_range(0, 31)), 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0};
            w.data = s0;
            w.we   = (w.rd != 5'd0);
            run_cycle($sformatf("rnd%0d", i), 1'b0, 1'b0, 1'b0, w);
        end

        // misaligned load followed by a stall: the error pulse must not repeat
        mis = vecs[3];
        run_cycle("mis_cap",   1'b0, 1'b0, 1'b0, mis);
        run_cycle("mis_stall", 1'b0, 1'b1, 1'b0, mis);
        run_cycle("mis_go",    1'b0, 1'b0, 1'b0, idle);

        // stall and flush around a write to r7
        s0 = 32'h0000_0077;
        w = '{1'b1, 1'b1, 5'd7, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h0000_0077, 1'b0};
        run_cycle("r7_cap", 1'b0, 1'b0, 1'b0, w);
        for (int i = 0; i < 3; i++) begin
            s0 = $urandom;
            s1 = $urandom;
            w = '{1'b1, 1'b1, 5'($urandom_range(1, 31)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 1'b1, 2'($urandom_range(0, 3)), 1'b1, 32'h0, 1'b0};
            run_cycle($sformatf("r7_stall%0d", i), 1'b0, 1'b1, 1'b0, w);
        end
        run_cycle("stall_flush", 1'b0, 1'b1, 1'b1, w);
        run_cycle("post_flush",  1'b0, 1'b0, 1'b0, idle);

        // counter wrap: preload retired to all ones with a valid stage
        s0 = 32'h1234_5678; s1 = 32'hAABB_CCDD;
        w = '{1'b1, 1'b1, 5'd2, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h1234_5678, 1'b0};
        run_cycle("pre_wrap", 1'b0, 1'b0, 1'b0, w);
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        chk("preload.retired", retired, 32'hFFFF_FFFF);
        m_ret = 32'hFFFF_FFFF;
        run_cycle("wrap", 1'b0, 1'b0, 1'b0, w);
        run_cycle("after_wrap", 1'b0, 1'b0, 1'b0, idle);

        // reset in the middle of a stall
        w = '{1'b1, 1'b1, 5'd20, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h1234_5678, 1'b0};
        run_cycle("rs_cap",    1'b0, 1'b0, 1'b0, w);
        run_cycle("rs_stall",  1'b0, 1'b1, 1'b0, w);
        run_cycle("rs_reset",  1'b1, 1'b1, 1'b0, w);
        run_cycle("rs_after",  1'b0, 1'b0, 1'b0, idle);
        run_cycle("rs_after2", 1'b0, 1'b0, 1'b0, idle);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
